// File: rtl/rd53_ttc_pkg.sv
// Shared constants, symbol tables and frame-kind type for the RD53 TTC transmit encoder.
package rd53_ttc_pkg;

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned SYM_W   = 8;
    localparam int unsigned TAG_W   = 5;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned PAT_W   = 4;

    localparam logic [FRAME_W-1:0] SYNC_WORD = 16'h817E;
    localparam logic [FRAME_W-1:0] NOOP_WORD = 16'h6969;

    // Indexed by the 4-bit trigger pattern; pattern 0 never forms a trigger frame.
    localparam logic [SYM_W-1:0] TRIG_SYM [1:15] = '{
        8'h2B, 8'h2D, 8'h2E, 8'h33, 8'h35, 8'h36, 8'h39, 8'h3A,
        8'h3C, 8'h4B, 8'h4D, 8'h4E, 8'h53, 8'h55, 8'h56
    };

    localparam logic [SYM_W-1:0] TAG_SYM [0:31] = '{
        8'h6A, 8'h6C, 8'h71, 8'h72, 8'h74, 8'h8B, 8'h8D, 8'h8E,
        8'h93, 8'h95, 8'h96, 8'h99, 8'h9A, 8'h9C, 8'hA3, 8'hA5,
        8'hA6, 8'hA9, 8'hAA, 8'hAC, 8'hB1, 8'hB2, 8'hB4, 8'hC3,
        8'hC5, 8'hC6, 8'hC9, 8'hCA, 8'hCC, 8'hD1, 8'hD2, 8'hD4
    };

    typedef enum logic [1:0] {
        TRIG,
        SYNC,
        CMD,
        NOOP
    } frame_kind_t;

endpackage

// File: rtl/rd53_frame_shifter.sv
// Frame-rate serializer: free-running bit counter, 16-bit shift register and frame-boundary load strobe.
module rd53_frame_shifter
    import rd53_ttc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] load_word,
    output logic [CNT_W-1:0]   bit_cnt,
    output logic               load_c,
    output logic               ttc_bit,
    output logic               frame_start
);

    logic [FRAME_W-1:0] shift_reg;

    // Last bit of the frame: the next word is loaded on this edge.
    assign load_c  = (bit_cnt == CNT_W'(FRAME_W - 1));
    assign ttc_bit = shift_reg[FRAME_W-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt     <= '0;
            shift_reg   <= SYNC_WORD;
            frame_start <= 1'b1;
        end else begin
            bit_cnt     <= bit_cnt + CNT_W'(1);
            frame_start <= load_c;
            if (load_c) begin
                shift_reg <= load_word;
            end else begin
                shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/rd53_ttc_encoder.sv
// RD53 TTC transmit encoder: samples triggers per BX, arbitrates trigger/sync/command/no-op frames and serializes them.
module rd53_ttc_encoder
    import rd53_ttc_pkg::*;
#(
    parameter int unsigned SYNC_PERIOD = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trig_in,
    input  logic [FRAME_W-1:0] cmd_data,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    output logic               ttc_bit,
    output logic               frame_start,
    output logic               trig_sent,
    output logic [TAG_W-1:0]   tag_out
);

    localparam int unsigned SYNC_CNT_W = 8;

    logic [CNT_W-1:0]      bit_cnt;
    logic                  load_c;
    logic [PAT_W-2:0]      trig_pat;
    logic [TAG_W-1:0]      tag;
    logic [SYNC_CNT_W-1:0] sync_cnt;
    logic [FRAME_W-1:0]    hold_data;

    logic [PAT_W-1:0]      pattern_c;
    logic                  sync_due_c;
    frame_kind_t           kind_c;
    logic [FRAME_W-1:0]    frame_word_c;

    rd53_frame_shifter u_shifter (
        .clk         (clk),
        .rst         (rst),
        .load_word   (frame_word_c),
        .bit_cnt     (bit_cnt),
        .load_c      (load_c),
        .ttc_bit     (ttc_bit),
        .frame_start (frame_start)
    );

    // The fourth BX sample is taken live on the boundary cycle itself.
    assign pattern_c  = {trig_pat, trig_in};
    assign sync_due_c = (sync_cnt == SYNC_CNT_W'(SYNC_PERIOD - 1));

    // BX0..BX2 trigger samples; each frame overwrites all three before use.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trig_pat <= '0;
        end else begin
            case (bit_cnt)
                CNT_W'(3):  trig_pat[2] <= trig_in;
                CNT_W'(7):  trig_pat[1] <= trig_in;
                CNT_W'(11): trig_pat[0] <= trig_in;
                default:    ;
            endcase
        end
    end

    // Frame arbitration: trigger, then due sync, then pending command, else no-op.
    always_comb begin
        kind_c       = NOOP;
        frame_word_c = NOOP_WORD;
        if (pattern_c != '0) begin
            kind_c       = TRIG;
            frame_word_c = {TRIG_SYM[pattern_c], TAG_SYM[tag]};
        end else if (sync_due_c) begin
            kind_c       = SYNC;
            frame_word_c = SYNC_WORD;
        end else if (!cmd_ready) begin
            kind_c       = CMD;
            frame_word_c = hold_data;
        end
    end

    // Counters, command holding register and frame-status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag       <= '0;
            sync_cnt  <= '0;
            hold_data <= '0;
            cmd_ready <= 1'b1;
            trig_sent <= 1'b0;
            tag_out   <= '0;
        end else begin
            trig_sent <= 1'b0;
            if (cmd_valid && cmd_ready) begin
                hold_data <= cmd_data;
                cmd_ready <= 1'b0;
            end
            if (load_c) begin
                if (kind_c == TRIG) begin
                    tag       <= tag + TAG_W'(1);
                    trig_sent <= 1'b1;
                    tag_out   <= tag;
                end
                if (kind_c == SYNC) begin
                    sync_cnt <= '0;
                end else if (!sync_due_c) begin
                    sync_cnt <= sync_cnt + SYNC_CNT_W'(1);
                end
                if (kind_c == CMD) begin
                    cmd_ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rd53_ttc_encoder.sv
// Scoreboard bench for rd53_ttc_encoder: stimulus queues expected frames, a monitor deserializes and compares.
module tb_rd53_ttc_encoder;

    logic        clk;
    logic        rst;
    logic        trig_in;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        ttc_bit;
    logic        frame_start;
    logic        trig_sent;
    logic [4:0]  tag_out;

    typedef struct {
        logic [15:0] word;
        logic        trig;
        logic [4:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] tag_tbl [0:31] = '{
        8'h6A, 8'h6C, 8'h71, 8'h72, 8'h74, 8'h8B, 8'h8D, 8'h8E,
        8'h93, 8'h95, 8'h96, 8'h99, 8'h9A, 8'h9C, 8'hA3, 8'hA5,
        8'hA6, 8'hA9, 8'hAA, 8'hAC, 8'hB1, 8'hB2, 8'hB4, 8'hC3,
        8'hC5, 8'hC6, 8'hC9, 8'hCA, 8'hCC, 8'hD1, 8'hD2, 8'hD4
    };

    rd53_ttc_encoder #(.SYNC_PERIOD(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .trig_in     (trig_in),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .ttc_bit     (ttc_bit),
        .frame_start (frame_start),
        .trig_sent   (trig_sent),
        .tag_out     (tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one frame (entered with bit_cnt == 0) and queues the word the DUT should send during it.
    task automatic drive_frame(input logic [3:0] pat, input logic [15:0] exp_word,
                               input logic exp_trig, input logic [4:0] exp_tag,
                               input int cmd_at, input logic [15:0] cmd_word,
                               input int rdy_at, input logic rdy_exp);
        exp_t e;
        e.word = exp_word;
        e.trig = exp_trig;
        e.tag  = exp_tag;
        exp_q.push_back(e);
        for (int b = 0; b < 16; b++) begin
            trig_in   = pat[3 - b / 4];
            cmd_valid = (b == cmd_at);
            cmd_data  = cmd_word;
            if (b == cmd_at) check("cmd_ready_at_accept", 32'(cmd_ready), 32'(1));
            if (b == rdy_at) check("cmd_ready_level", 32'(cmd_ready), 32'(rdy_exp));
            @(negedge clk);
        end
        trig_in   = 1'b0;
        cmd_valid = 1'b0;
    endtask

    task automatic idle_frame(input logic [15:0] exp_word, input logic exp_trig, input logic [4:0] exp_tag);
        drive_frame(4'b0000, exp_word, exp_trig, exp_tag, -1, 16'h0000, -1, 1'b0);
    endtask

    // Monitor: deserializes each frame and checks it against the scoreboard when the next frame starts.
    initial begin
        logic [15:0] cur;
        int          nb;
        logic        st_trig;
        logic [4:0]  st_tag;
        exp_t        e;
        cur = '0;
        nb = 0;
        st_trig = 1'b0;
        st_tag = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                nb = 0;
            end else if (frame_start) begin
                if (nb != 0) begin
                    check("frame_period", 32'(nb), 32'(16));
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got %0h expected none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_word", 32'(cur), 32'(e.word));
                        check("trig_sent", 32'(st_trig), 32'(e.trig));
                        check("tag_out", 32'(st_tag), 32'(e.tag));
                    end
                end
                cur     = {15'b0, ttc_bit};
                nb      = 1;
                st_trig = trig_sent;
                st_tag  = tag_out;
            end else begin
                cur = {cur[14:0], ttc_bit};
                nb++;
                if (trig_sent) check("trig_sent_width", 32'(trig_sent), 32'(0));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        trig_in   = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        repeat (3) @(negedge clk);
        check("reset_ttc_bit", 32'(ttc_bit), 32'(1));
        check("reset_frame_start", 32'(frame_start), 32'(1));
        check("reset_cmd_ready", 32'(cmd_ready), 32'(1));
        check("reset_trig_sent", 32'(trig_sent), 32'(0));
        check("reset_tag_out", 32'(tag_out), 32'(0));
        rst = 1'b1;

        // Idle: sync, 31 no-ops, sync.
        idle_frame(16'h817E, 1'b0, 5'd0);
        for (int i = 0; i < 31; i++) idle_frame(16'h6969, 1'b0, 5'd0);
        idle_frame(16'h817E, 1'b0, 5'd0);

        // Single trigger at BX0 -> pattern 1000.
        drive_frame(4'b1000, 16'h6969, 1'b0, 5'd0, -1, 16'h0000, -1, 1'b0);
        idle_frame(16'h3A6A, 1'b1, 5'd0);
        idle_frame(16'h6969, 1'b0, 5'd0);

        // Command accepted alongside pattern 0101 waits behind the trigger frame.
        drive_frame(4'b0101, 16'h6969, 1'b0, 5'd0, 2, 16'h5A5A, 3, 1'b0);
        drive_frame(4'b0000, 16'h356C, 1'b1, 5'd1, -1, 16'h0000, 5, 1'b0);
        drive_frame(4'b0000, 16'h5A5A, 1'b0, 5'd1, -1, 16'h0000, 1, 1'b1);
        idle_frame(16'h6969, 1'b0, 5'd1);

        // Continuous triggers for 40 frames: tags 2..41 mod 32, sync held off.
        for (int i = 0; i < 40; i++) begin
            if (i == 0) begin
                drive_frame(4'b1111, 16'h6969, 1'b0, 5'd1, -1, 16'h0000, -1, 1'b0);
            end else begin
                drive_frame(4'b1111, {8'h56, tag_tbl[(i + 1) % 32]}, 1'b1, 5'((i + 1) % 32),
                            -1, 16'h0000, -1, 1'b0);
            end
        end
        idle_frame({8'h56, tag_tbl[9]}, 1'b1, 5'd9);
        idle_frame(16'h817E, 1'b0, 5'd9);

        // Run up to a due sync, then collide trigger + sync + pending command.
        for (int i = 0; i < 30; i++) idle_frame(16'h6969, 1'b0, 5'd9);
        drive_frame(4'b0010, 16'h6969, 1'b0, 5'd9, 4, 16'hC3C3, -1, 1'b0);
        drive_frame(4'b0000, 16'h2D96, 1'b1, 5'd10, -1, 16'h0000, 5, 1'b0);
        drive_frame(4'b0000, 16'h817E, 1'b0, 5'd10, -1, 16'h0000, 8, 1'b0);
        drive_frame(4'b0000, 16'hC3C3, 1'b0, 5'd10, -1, 16'h0000, 1, 1'b1);
        idle_frame(16'h6969, 1'b0, 5'd10);

        // Reset at bit_cnt 7 with a command pending; truncated frame is not queued.
        for (int b = 0; b < 7; b++) begin
            cmd_valid = (b == 1);
            cmd_data  = 16'h1234;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("pending_before_reset", 32'(cmd_ready), 32'(0));
        #2 rst = 1'b0;
        #1;
        check("midreset_ttc_bit", 32'(ttc_bit), 32'(1));
        check("midreset_cmd_ready", 32'(cmd_ready), 32'(1));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        drive_frame(4'b0001, 16'h817E, 1'b0, 5'd0, -1, 16'h0000, -1, 1'b0);
        idle_frame(16'h2B6A, 1'b1, 5'd0);
        idle_frame(16'h6969, 1'b0, 5'd0);
        idle_frame(16'h6969, 1'b0, 5'd0);

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
